// File: rtl/nx_stream_dist_arbiter_if.sv
// Handshake bundle between inbound requesters, the arbiter and the stream distributor.
// The arbiter connects through the slave modport; the requester/distributor side uses master.
interface nx_stream_dist_arbiter_if #(
    parameter int STREAM_WIDTH   = 31,
    parameter int REQUESTERS     = 4,
    parameter int DROP_CNT_WIDTH = 8
);
    localparam int IDX_W = $clog2(REQUESTERS);

    logic [REQUESTERS*STREAM_WIDTH-1:0] req_data_i;
    logic [REQUESTERS*2-1:0]            req_dir_i;
    logic [REQUESTERS-1:0]              req_valid_i;
    logic [REQUESTERS-1:0]              req_ready_o;
    logic [3:0]                         present_i;
    logic [STREAM_WIDTH-1:0]            dist_data_o;
    logic [1:0]                         dist_dir_o;
    logic                               dist_valid_o;
    logic                               dist_ready_i;
    logic [DROP_CNT_WIDTH-1:0]          drop_count_o;
    logic [IDX_W-1:0]                   grant_idx_o;

    modport slave (
        input  req_data_i, req_dir_i, req_valid_i, present_i, dist_ready_i,
        output req_ready_o, dist_data_o, dist_dir_o, dist_valid_o, drop_count_o, grant_idx_o
    );

    modport master (
        output req_data_i, req_dir_i, req_valid_i, present_i, dist_ready_i,
        input  req_ready_o, dist_data_o, dist_dir_o, dist_valid_o, drop_count_o, grant_idx_o
    );
endinterface

// File: rtl/nx_stream_dist_arbiter.sv
// Round-robin merge of inbound requester streams into one registered distributor slot;
// messages for absent neighbours are discarded and counted instead of stalling the slot.
module nx_stream_dist_arbiter #(
    parameter int STREAM_WIDTH   = 31,
    parameter int REQUESTERS     = 4,
    parameter int DROP_CNT_WIDTH = 8
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    nx_stream_dist_arbiter_if.slave     bus
);
    localparam int IDX_W = $clog2(REQUESTERS);

    logic [IDX_W-1:0]          ptr_q;
    logic [IDX_W-1:0]          gidx_q;
    logic [DROP_CNT_WIDTH-1:0] drop_q;
    logic [STREAM_WIDTH-1:0]   data_p1;
    logic [1:0]                dir_p1;
    logic                      vld_p1;

    logic                      slot_free;
    logic                      found;
    logic [IDX_W-1:0]          win;
    logic [1:0]                win_dir;
    logic [STREAM_WIDTH-1:0]   win_data;
    logic                      grant;
    logic                      load;
    logic                      drop;
    logic [REQUESTERS-1:0]     ready;

    function automatic logic [IDX_W-1:0] wrap_idx(input logic [IDX_W-1:0] base, input int off);
        int s;
        s = (int'(base) + off) % REQUESTERS;
        return s[IDX_W-1:0];
    endfunction

    function automatic logic [DROP_CNT_WIDTH-1:0] sat_inc(input logic [DROP_CNT_WIDTH-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    assign slot_free = !vld_p1 || bus.dist_ready_i;

    // Stage p0: round-robin search starting at the pointer, ascending with wrap
    always_comb begin
        found = 1'b0;
        win   = '0;
        for (int k = 0; k < REQUESTERS; k++) begin
            if (!found && bus.req_valid_i[wrap_idx(ptr_q, k)]) begin
                found = 1'b1;
                win   = wrap_idx(ptr_q, k);
            end
        end
    end

    assign win_dir  = bus.req_dir_i[int'(win)*2 +: 2];
    assign win_data = bus.req_data_i[int'(win)*STREAM_WIDTH +: STREAM_WIDTH];
    // Gating with rst_i keeps every ready low while the block is held in reset.
    assign grant    = rst_i && slot_free && found;
    assign load     = grant && bus.present_i[win_dir];
    assign drop     = grant && !bus.present_i[win_dir];

    always_comb begin
        ready = '0;
        if (grant) ready[win] = 1'b1;
    end

    // Stage p1: output slot, pointer and drop counter
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            data_p1 <= '0;
            dir_p1  <= '0;
            vld_p1  <= 1'b0;
            ptr_q   <= '0;
            gidx_q  <= '0;
            drop_q  <= '0;
        end else begin
            if (load) begin
                data_p1 <= win_data;
                dir_p1  <= win_dir;
                vld_p1  <= 1'b1;
            end else if (bus.dist_ready_i) begin
                vld_p1  <= 1'b0;
            end
            if (grant) begin
                ptr_q  <= wrap_idx(win, 1);
                gidx_q <= win;
            end
            if (drop) drop_q <= sat_inc(drop_q);
        end
    end

    assign bus.req_ready_o  = ready;
    assign bus.dist_data_o  = data_p1;
    assign bus.dist_dir_o   = dir_p1;
    assign bus.dist_valid_o = vld_p1;
    assign bus.drop_count_o = drop_q;
    assign bus.grant_idx_o  = gidx_q;
endmodule

// File: tb/tb_nx_stream_dist_arbiter.sv
// Bench for nx_stream_dist_arbiter: directed scenarios with literal expectations plus a
// randomized run against a cycle-level behavioural model; two DUTs differ only in drop counter width.
module tb_nx_stream_dist_arbiter;
    localparam int SW = 31;
    localparam int R  = 4;

    logic clk = 1'b0;
    logic rst;
    logic [R*SW-1:0] req_data;
    logic [R*2-1:0]  req_dir;
    logic [R-1:0]    req_valid;
    logic [3:0]      present;
    logic            dist_ready;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    nx_stream_dist_arbiter_if #(.STREAM_WIDTH(SW), .REQUESTERS(R), .DROP_CNT_WIDTH(8)) bus_a ();
    nx_stream_dist_arbiter_if #(.STREAM_WIDTH(SW), .REQUESTERS(R), .DROP_CNT_WIDTH(2)) bus_b ();

    assign bus_a.req_data_i   = req_data;
    assign bus_a.req_dir_i    = req_dir;
    assign bus_a.req_valid_i  = req_valid;
    assign bus_a.present_i    = present;
    assign bus_a.dist_ready_i = dist_ready;
    assign bus_b.req_data_i   = req_data;
    assign bus_b.req_dir_i    = req_dir;
    assign bus_b.req_valid_i  = req_valid;
    assign bus_b.present_i    = present;
    assign bus_b.dist_ready_i = dist_ready;

    nx_stream_dist_arbiter #(.STREAM_WIDTH(SW), .REQUESTERS(R), .DROP_CNT_WIDTH(8)) dut_a (
        .clk_i(clk), .rst_i(rst), .bus(bus_a)
    );
    nx_stream_dist_arbiter #(.STREAM_WIDTH(SW), .REQUESTERS(R), .DROP_CNT_WIDTH(2)) dut_b (
        .clk_i(clk), .rst_i(rst), .bus(bus_b)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: state as seen after the most recent clock edge
    int              m_ptr, m_gidx, m_drop_a, m_drop_b;
    bit              m_vld;
    logic [SW-1:0]   m_data;
    logic [1:0]      m_dir;
    logic [R-1:0]    exp_rdy;
    logic [1:0]      w_dir;
    int              w;

    always @(negedge clk) begin
        if (!rst) begin
            m_ptr = 0; m_gidx = 0; m_drop_a = 0; m_drop_b = 0;
            m_vld = 1'b0; m_data = '0; m_dir = '0;
        end
        check("m_valid_a", 64'(bus_a.dist_valid_o), 64'(m_vld));
        check("m_data_a",  64'(bus_a.dist_data_o),  64'(m_data));
        check("m_dir_a",   64'(bus_a.dist_dir_o),   64'(m_dir));
        check("m_gidx_a",  64'(bus_a.grant_idx_o),  64'(m_gidx));
        check("m_drop_a",  64'(bus_a.drop_count_o), 64'(m_drop_a));
        check("m_valid_b", 64'(bus_b.dist_valid_o), 64'(m_vld));
        check("m_data_b",  64'(bus_b.dist_data_o),  64'(m_data));
        check("m_drop_b",  64'(bus_b.drop_count_o), 64'(m_drop_b));
        exp_rdy = '0;
        w = -1;
        if (rst && (!m_vld || dist_ready)) begin
            for (int k = 0; k < R; k++) begin
                if (w < 0 && req_valid[(m_ptr + k) % R]) w = (m_ptr + k) % R;
            end
            if (w >= 0) exp_rdy[w] = 1'b1;
        end
        check("m_ready_a", 64'(bus_a.req_ready_o), 64'(exp_rdy));
        check("m_ready_b", 64'(bus_b.req_ready_o), 64'(exp_rdy));
        if (rst) begin
            if (w >= 0) begin
                m_ptr  = (w + 1) % R;
                m_gidx = w;
                w_dir  = req_dir[w*2 +: 2];
                if (present[w_dir]) begin
                    m_data = req_data[w*SW +: SW];
                    m_dir  = w_dir;
                    m_vld  = 1'b1;
                end else begin
                    m_drop_a = (m_drop_a < 255) ? m_drop_a + 1 : 255;
                    m_drop_b = (m_drop_b < 3) ? m_drop_b + 1 : 3;
                    if (dist_ready) m_vld = 1'b0;
                end
            end else if (dist_ready) begin
                m_vld = 1'b0;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        step();
        rst = 1'b0;
        @(negedge clk);
        step();
        rst = 1'b1;
    endtask

    task automatic set_req(input int r, input logic [SW-1:0] d, input logic [1:0] dr);
        req_data[r*SW +: SW] = d;
        req_dir[r*2 +: 2]    = dr;
    endtask

    logic [R-1:0] rdy_seen;

    initial begin
        rst = 1'b0; req_valid = 4'b1111; present = 4'hF; dist_ready = 1'b1;
        req_data = '0; req_dir = '0;
        for (int r = 0; r < R; r++) set_req(r, SW'(r), 2'(r % 4));
        @(negedge clk);
        check("rst_ready", 64'(bus_a.req_ready_o), 64'd0);
        check("rst_valid", 64'(bus_a.dist_valid_o), 64'd0);
        check("rst_drop",  64'(bus_a.drop_count_o), 64'd0);
        check("rst_gidx",  64'(bus_a.grant_idx_o), 64'd0);

        // Full-rate rotation 0,1,2,3,0,...
        step();
        rst = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("rot_ready", 64'(bus_a.req_ready_o), 64'(4'b0001 << (i % 4)));
            if (i == 0) check("rot_first_valid", 64'(bus_a.dist_valid_o), 64'd0);
            else begin
                check("rot_valid", 64'(bus_a.dist_valid_o), 64'd1);
                check("rot_data",  64'(bus_a.dist_data_o), 64'((i - 1) % 4));
            end
        end

        // Sparse requesters 1 and 3
        req_valid = 4'b0000;
        do_reset();
        req_valid = 4'b0010;
        @(negedge clk);
        check("sparse_r1", 64'(bus_a.req_ready_o), 64'b0010);
        step();
        req_valid = 4'b1010;
        @(negedge clk); check("sparse_r3", 64'(bus_a.req_ready_o), 64'b1000);
        @(negedge clk); check("sparse_r1b", 64'(bus_a.req_ready_o), 64'b0010);
        @(negedge clk); check("sparse_r3b", 64'(bus_a.req_ready_o), 64'b1000);

        // Backpressure hold then no-bubble resume
        req_valid = 4'b0000;
        do_reset();
        set_req(0, SW'(32'h55), 2'd2);
        req_valid = 4'b0001; dist_ready = 1'b0;
        @(negedge clk);
        check("hold_grant", 64'(bus_a.req_ready_o), 64'b0001);
        step();
        req_valid = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("hold_data",  64'(bus_a.dist_data_o), 64'h55);
            check("hold_dir",   64'(bus_a.dist_dir_o), 64'd2);
            check("hold_ready", 64'(bus_a.req_ready_o), 64'd0);
        end
        step();
        dist_ready = 1'b1;
        @(negedge clk);
        check("resume_ready", 64'(bus_a.req_ready_o), 64'b0010);
        @(negedge clk);
        check("resume_valid", 64'(bus_a.dist_valid_o), 64'd1);
        check("resume_data",  64'(bus_a.dist_data_o), 64'd1);

        // Drop to absent neighbour
        req_valid = 4'b0000;
        do_reset();
        present = 4'b1011;
        set_req(0, SW'(32'h77), 2'd2);
        req_valid = 4'b0001;
        @(negedge clk);
        check("drop_ready", 64'(bus_a.req_ready_o), 64'b0001);
        step();
        req_valid = 4'b0011;
        @(negedge clk);
        check("drop_valid", 64'(bus_a.dist_valid_o), 64'd0);
        check("drop_count", 64'(bus_a.drop_count_o), 64'd1);
        check("drop_ptr",   64'(bus_a.req_ready_o), 64'b0010);

        // Saturation of the narrow counter
        req_valid = 4'b0000;
        do_reset();
        present = 4'b0000;
        req_valid = 4'b0001;
        @(negedge clk);
        for (int i = 1; i <= 5; i++) begin
            @(negedge clk);
            check("sat_narrow", 64'(bus_b.drop_count_o), 64'((i < 3) ? i : 3));
            check("sat_wide",   64'(bus_a.drop_count_o), 64'(i));
        end

        // Asynchronous reset mid-stream
        present = 4'hF;
        for (int r = 0; r < R; r++) set_req(r, SW'(r + 16), 2'(r));
        req_valid = 4'b1111;
        repeat (3) step();
        @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        check("arst_valid", 64'(bus_a.dist_valid_o), 64'd0);
        check("arst_drop",  64'(bus_a.drop_count_o), 64'd0);
        check("arst_ready", 64'(bus_a.req_ready_o), 64'd0);
        @(negedge clk);
        step();
        rst = 1'b1;
        @(negedge clk);
        check("arst_first", 64'(bus_a.req_ready_o), 64'b0001);

        // Randomized traffic; requesters hold stable while waiting
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk);
            rdy_seen = bus_a.req_ready_o;
            step();
            for (int r = 0; r < R; r++) begin
                if (!(req_valid[r] && !rdy_seen[r])) begin
                    req_valid[r] = ($urandom() % 4) != 0;
                    set_req(r, SW'($urandom()), 2'($urandom()));
                end
            end
            if ($urandom() % 8 == 0) present = 4'($urandom());
            dist_ready = ($urandom() % 4) != 0;
        end
        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/nx_stream_dist_arbiter.md
Name: nx_stream_dist_arbiter

Overview:
- Round-robin arbiter that merges REQUESTERS inbound message streams into the single directed stream feeding the node's stream distributor.
- Each requester presents data plus a 2-bit direction.
- Messages aimed at a neighbour that is not present are discarded and counted, so they cannot stall the distributor.
- One registered output slot: one-cycle latency, full throughput.

Parameters:
STREAM_WIDTH, 31, width of one message
REQUESTERS, 4, number of inbound requesters (2..8)
DROP_CNT_WIDTH, 8, width of saturating dropped-message counter

Ports:
clk_i  input  1  clock
rst_i  input  1  asynchronous, active-low reset
req_data_i  input  REQUESTERS*STREAM_WIDTH  packed message per requester; requester r at [r*STREAM_WIDTH +: STREAM_WIDTH]
req_dir_i  input  REQUESTERS*2  packed direction per requester: 0=north, 1=east, 2=south, 3=west
req_valid_i  input  REQUESTERS  per-requester valid
req_ready_o  output  REQUESTERS  per-requester ready; asserts only for the granted requester
present_i  input  4  neighbour present mask, bit index = direction code
dist_data_o  output  STREAM_WIDTH  message to distributor
dist_dir_o  output  2  direction to distributor
dist_valid_o  output  1  output slot holds a message
dist_ready_i  input  1  distributor accepts
drop_count_o  output  DROP_CNT_WIDTH  messages discarded for absent destination, saturating
grant_idx_o  output  $clog2(REQUESTERS)  index of the last granted requester (debug)

Behaviour:
- Reset (rst_i low, asynchronous): dist_valid_o=0, dist_data_o=0, dist_dir_o=0, drop_count_o=0, grant_idx_o=0, RR pointer=0. req_ready_o is 0 while in reset.
- slot_free = !dist_valid_o || dist_ready_i. Arbitration happens only in cycles where slot_free=1.
- Round-robin: search req_valid_i starting at the RR pointer, ascending with wrap. The first valid requester wins. At most one grant per cycle.
- req_ready_o[w] = slot_free && req_valid_i[w] for the winner w only. It is combinational from req_valid_i, dist_valid_o, dist_ready_i and the pointer.
- On a grant:
  - RR pointer <= (w+1) mod REQUESTERS.
  - grant_idx_o <= w.
  - If present_i[dir_w]=1: at the clock edge, load dist_data_o/dist_dir_o from requester w and set dist_valid_o=1.
  - If present_i[dir_w]=0: drop the message. The slot is not loaded. drop_count_o increments and saturates at all-ones.
- If the slot drains (dist_ready_i && dist_valid_o) and there is no load this cycle, dist_valid_o <= 0.
- If the slot drains and a new message loads in the same cycle, dist_valid_o stays 1 and the data updates. No bubble, so 1 msg/cycle is sustained.
- dist_valid_o=1 && dist_ready_i=0: output holds stable (data, dir, valid). No grant is issued and req_ready_o is all 0.
- No grant this cycle (no valid requesters, or slot not free): pointer, grant_idx_o and drop_count_o hold.
- A dropped message consumes a grant cycle and advances the pointer. It does not affect dist_valid_o except through the normal drain.
- present_i is sampled only at grant time. A message already in the slot is unaffected by later changes to present_i.
- Requesters must hold data and dir stable while valid && !ready. The arbiter does not check this.
- Latency: accept edge to dist_valid_o high is 1 cycle.
- Reset asserted mid-transfer: the slot content is lost immediately and valid clears asynchronously. Nothing is in flight after reset releases.

Test Plan:
- Reset, all req_valid_i=1, all present, dist_ready_i=1, requester r sends data=r, dir=r%4 -> output sequence data 0,1,2,3,0,... on consecutive cycles; req_ready_o one-hot rotating 0001,0010,0100,1000; first dist_valid_o one cycle after the first grant.
- Requesters 1 and 3 valid, pointer=2 after a grant to requester 1 -> requester 3 wins next, then 1; requesters 0 and 2 are never granted while idle.
- Slot loaded with 0x55/dir 2, dist_ready_i=0 for 5 cycles with requesters valid -> output stable at 0x55/2, req_ready_o=0 throughout; on dist_ready_i=1, the next message loads in the same edge with no bubble.
- present_i=4'b1011, requester 0 sends dir=2 -> req_ready_o[0] pulses, dist_valid_o stays 0, drop_count_o 0->1, pointer advances to 1.
- DROP_CNT_WIDTH=2, 5 drops to an absent direction -> drop_count_o reads 1,2,3,3,3.
- Assert rst_i low mid-stream with dist_valid_o=1 -> dist_valid_o=0 and drop_count_o=0 before the next clock edge; after release, the first grant goes to requester 0.
